// File: rtl/prog_loader_if.sv
`default_nettype none
//==============================================================================
// Module      : prog_loader_if
// Description : Byte-stream input and instruction-memory write port of the
//               boot program loader, plus its boot status outputs.
// Revision    : 1.0 - initial release
//==============================================================================
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_wr;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    // Byte source / observer side
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_wr, cpu_reset, done, error
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_wr, cpu_reset, done, error
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
//==============================================================================
// Module      : prog_loader
// Description : Loads a length-prefixed, XOR-checksummed byte image into
//               instruction memory and holds the CPU in reset until verified.
// Revision    : 1.0 - initial release
//==============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0
) (
    input  wire             clk,
    input  wire             reset,
    prog_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_base_addr = ADDR_WIDTH'(BASE_ADDR);
    // Largest word count that fits between BASE_ADDR and the top of memory
    localparam logic [32:0] c_max_words =
        33'((64'd1 << (ADDR_WIDTH - 2)) - 64'(BASE_ADDR / 4));

    state_t                r_state;
    state_t                w_state_next;

    logic [15:0]           r_len;
    logic [15:0]           r_word_idx;
    logic [1:0]            r_lane;
    logic [23:0]           r_shift;
    logic [7:0]            r_xor;

    logic                  r_rx_ready;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_error;

    logic                  w_xfer;
    logic [15:0]           w_len_full;
    logic                  w_len_too_big;
    logic                  w_last_word;
    logic                  w_word_end;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    assign w_xfer        = bus.rx_valid && r_rx_ready;
    assign w_len_full    = {bus.rx_data, r_len[7:0]};
    assign w_len_too_big = {17'd0, w_len_full} > c_max_words;
    assign w_last_word   = (r_word_idx == (r_len - 16'd1));
    assign w_word_end    = (r_lane == 2'd3);
    assign w_word_addr   = c_base_addr + ADDR_WIDTH'({r_word_idx, 2'b00});

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN_LO: begin
                if (w_xfer) begin
                    w_state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_too_big) begin
                        w_state_next = S_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && w_word_end && w_last_word) begin
                    w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_next = (bus.rx_data == r_xor) ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  w_state_next = S_DONE;
            S_ERROR: w_state_next = S_ERROR;
            default: w_state_next = S_LEN_LO;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs; status flags follow the next state so
    // they change in the cycle after the deciding transfer.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len       <= 16'd0;
            r_word_idx  <= 16'd0;
            r_lane      <= 2'd0;
            r_shift     <= 24'd0;
            r_xor       <= 8'd0;
            r_rx_ready  <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= c_base_addr;
            r_mem_wdata <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rx_ready  <= (w_state_next != S_DONE) && (w_state_next != S_ERROR);
            r_done      <= (w_state_next == S_DONE);
            r_error     <= (w_state_next == S_ERROR);
            r_cpu_reset <= (w_state_next != S_DONE);
            r_mem_wr    <= 1'b0;

            if (w_xfer) begin
                case (r_state)
                    S_LEN_LO: begin
                        r_len[7:0] <= bus.rx_data;
                        r_xor      <= r_xor ^ bus.rx_data;
                    end
                    S_LEN_HI: begin
                        r_len[15:8] <= bus.rx_data;
                        r_xor       <= r_xor ^ bus.rx_data;
                    end
                    S_DATA: begin
                        r_xor  <= r_xor ^ bus.rx_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_shift[7:0]   <= bus.rx_data;
                            2'd1: r_shift[15:8]  <= bus.rx_data;
                            2'd2: r_shift[23:16] <= bus.rx_data;
                            default: begin
                                r_mem_wdata <= {bus.rx_data, r_shift};
                                r_mem_addr  <= w_word_addr;
                                r_mem_wr    <= 1'b1;
                                r_word_idx  <= r_word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

endmodule
`default_nettype wire
